// File: rtl/mm_pkg.sv
// mm_pkg: shared types and sizes for the matrix-multiply sequencer
package mm_pkg;
  localparam int N = 2;
  localparam int OPERAND_BYTES = 2 * N * N;
  localparam int RESULT_BYTES = 2 * N * N;
  localparam int EW = 8;
  localparam int AW = 17;
  localparam int RW = 16;
  typedef enum logic [1:0] {LOAD, COMPUTE, SEND} state_t;
  // Reduce the 17-bit accumulator to a 16-bit result (saturate when MM_SAT_EN, else wrap)
  function automatic logic [RW-1:0] reduce(input logic [AW-1:0] acc);
`ifdef MM_SAT_EN
    return acc[AW-1] ? '1 : acc[RW-1:0];
`else
    return acc[RW-1:0];
`endif
  endfunction
endpackage

// File: rtl/mm_mac.sv
// mm_mac: registered 8x8 multiply-accumulate into a 17-bit accumulator
module mm_mac
  import mm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear_acc,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [AW-1:0] acc
);
  logic [2*EW-1:0] prod;
  logic [AW-1:0] acc_d, acc_q;
  // Product restarts the sum when clear_acc, otherwise adds to the running total
  always_comb begin
    prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
    acc_d = en ? (clear_acc ? '0 : acc_q) + {1'b0, prod} : acc_q;
  end
  // Accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: loads 2x2 operands from RX, computes C=A*B on one MAC, streams C to TX (MM_SAT_EN selects saturation)
module mm_sequencer #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  import mm_pkg::*;
  state_t state_q, state_d;
  logic [2:0] ld_q, ld_d, cnt_q, cnt_d, tx_idx_q, tx_idx_d, tx_nxt;
  logic [1:0] wr_idx_q, wr_idx_d;
  logic wr_q, wr_d, tx_valid_q, tx_valid_d, done_q, done_d, overrun_q, overrun_d, mac_en;
  logic [EW-1:0] tx_data_q, tx_data_d;
  logic [EW-1:0] op_q [OPERAND_BYTES];
  logic [EW-1:0] op_d [OPERAND_BYTES];
  logic [RW-1:0] c_q [N*N];
  logic [RW-1:0] c_d [N*N];
  logic [RW-1:0] c_nxt;
  logic [AW-1:0] acc;
  // cnt_q = {i, j, k}: A[i][k] sits at slot {0,i,k}, B[k][j] at slot {1,k,j}
  assign mac_en = state_q == COMPUTE && !clr;
  mm_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mac_en),
    .clear_acc (!cnt_q[0]),
    .a         (op_q[{1'b0, cnt_q[2], cnt_q[0]}]),
    .b         (op_q[{1'b1, cnt_q[0], cnt_q[1]}]),
    .acc       (acc)
  );
  // Byte to present next: index 0 on entry to SEND, else the one after the current byte
  assign tx_nxt = state_q == SEND ? tx_idx_q + 3'd1 : 3'd0;
  assign c_nxt = c_q[tx_nxt[2:1]];
  // Next-state, index, register-file and output logic
  always_comb begin
    state_d = state_q;
    ld_d = ld_q;
    cnt_d = cnt_q;
    tx_idx_d = tx_idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    done_d = 1'b0;
    overrun_d = overrun_q;
    op_d = op_q;
    c_d = c_q;
    wr_d = 1'b0;
    wr_idx_d = wr_idx_q;
    if (wr_q) c_d[wr_idx_q] = reduce(acc);
    if (clr) begin
      state_d = LOAD;
      ld_d = '0;
      cnt_d = '0;
      tx_idx_d = '0;
      tx_valid_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (rx_valid && state_q != LOAD) overrun_d = 1'b1;
      if (state_q == LOAD && rx_valid) begin
        op_d[ld_q] = rx_data;
        ld_d = ld_q + 3'd1;
        cnt_d = '0;
        if (ld_q == 3'(OPERAND_BYTES - 1)) state_d = COMPUTE;
      end
      if (state_q == COMPUTE) begin
        cnt_d = cnt_q + 3'd1;
        wr_d = cnt_q[0];
        wr_idx_d = cnt_q[2:1];
        if (cnt_q == 3'd7) begin
          state_d = SEND;
          tx_valid_d = 1'b1;
          tx_idx_d = '0;
          tx_data_d = tx_nxt[0] ? c_nxt[7:0] : c_nxt[15:8];
        end
      end
      if (state_q == SEND && tx_valid_q && tx_ready) begin
        if (tx_idx_q == 3'(RESULT_BYTES - 1)) begin
          state_d = LOAD;
          tx_valid_d = 1'b0;
          done_d = 1'b1;
          ld_d = '0;
        end else begin
          tx_idx_d = tx_nxt;
          tx_data_d = tx_nxt[0] ? c_nxt[7:0] : c_nxt[15:8];
        end
      end
    end
  end
  // State and register files, all zeroed on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD;
      ld_q <= '0;
      cnt_q <= '0;
      tx_idx_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
      op_q <= '{default: '0};
      c_q <= '{default: '0};
      wr_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q <= ld_d;
      cnt_q <= cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      done_q <= done_d;
      overrun_q <= overrun_d;
      op_q <= op_d;
      c_q <= c_d;
      wr_q <= wr_d;
      wr_idx_q <= wr_idx_d;
    end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = state_q != LOAD;
  assign done = done_q;
  assign overrun = overrun_q;
endmodule
